// File: rtl/ifetch_unit_if.sv
// Fetch-unit bundle: the instruction-cache request channel, the decode queue-head
// channel and the fetch control/redirect inputs. "master" is the fetch unit side.
interface ifetch_unit_if #(
    parameter int QDEPTH = 4
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic        fetch_enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] ic_addr;
    logic        ic_req;
    logic [31:0] ic_data;
    logic        ic_ready;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [CW-1:0] q_count;

    modport master (
        input  fetch_enable, redirect_valid, redirect_pc, ic_data, ic_ready, instr_ready,
        output ic_addr, ic_req, instr_valid, instr_data, instr_pc, q_count
    );

    modport slave (
        output fetch_enable, redirect_valid, redirect_pc, ic_data, ic_ready, instr_ready,
        input  ic_addr, ic_req, instr_valid, instr_data, instr_pc, q_count
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues word fetches to the I-cache, one outstanding at a time,
// and buffers responses in a small circular queue feeding decode. Redirects flush the queue.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    ifetch_unit_if.master bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          ic_req_q, ic_req_d;
    logic [31:0]   ic_addr_q, ic_addr_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   q_data_q [QDEPTH];
    logic [31:0]   q_pc_q   [QDEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          done_s;
    logic          pop_s;
    logic          push_s;
    logic          room_s;
    logic          room_after_s;
    logic [31:0]   redir_tgt_s;
    logic [31:0]   seq_pc_s;
    logic [CW:0]   occ_after_s;

    assign done_s      = ic_req_q & bus.ic_ready;
    assign pop_s       = (count_q != {CW{1'b0}}) & bus.instr_ready;
    assign redir_tgt_s = {bus.redirect_pc[31:2], 2'b00};
    assign seq_pc_s    = ic_addr_q + 32'd4;
    // Occupancy once the completing response is pushed; the next request must still fit.
    assign occ_after_s  = {1'b0, count_q} + {{CW{1'b0}}, 1'b1} - {{CW{1'b0}}, pop_s};
    assign room_s       = (count_q < CW'(QDEPTH));
    assign room_after_s = (occ_after_s < (CW+1)'(QDEPTH));

    // Fetch FSM next-state, request address and fetch PC update.
    always_comb begin
        state_d    = state_q;
        ic_req_d   = ic_req_q;
        ic_addr_d  = ic_addr_q;
        fetch_pc_d = fetch_pc_q;
        push_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.redirect_valid) begin
                    fetch_pc_d = redir_tgt_s;
                end else if (bus.fetch_enable && room_s) begin
                    state_d   = ST_REQ;
                    ic_req_d  = 1'b1;
                    ic_addr_d = fetch_pc_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ, ST_DISCARD: begin
                if (done_s) begin
                    if (bus.redirect_valid) begin
                        fetch_pc_d = redir_tgt_s;
                        if (bus.fetch_enable) begin
                            state_d   = ST_REQ;
                            ic_req_d  = 1'b1;
                            ic_addr_d = redir_tgt_s;
                        end else begin
                            state_d  = ST_IDLE;
                            ic_req_d = 1'b0;
                        end
                    end else if (state_q == ST_REQ) begin
                        push_s     = 1'b1;
                        fetch_pc_d = seq_pc_s;
                        if (bus.fetch_enable && room_after_s) begin
                            ic_addr_d = seq_pc_s;
                        end else begin
                            state_d  = ST_IDLE;
                            ic_req_d = 1'b0;
                        end
                    end else begin
                        // Stale response dropped; restart at the redirect target.
                        if (bus.fetch_enable && room_s) begin
                            state_d   = ST_REQ;
                            ic_addr_d = fetch_pc_q;
                        end else begin
                            state_d  = ST_IDLE;
                            ic_req_d = 1'b0;
                        end
                    end
                end else if (bus.redirect_valid) begin
                    fetch_pc_d = redir_tgt_s;
                    state_d    = ST_DISCARD;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                ic_req_d = 1'b0;
            end
        endcase
    end

    // Queue pointer and occupancy update; a redirect flushes and overrides any pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.redirect_valid) begin
            head_d  = {PW{1'b0}};
            tail_d  = {PW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            if (push_s) begin
                tail_d = tail_q + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                head_d = head_q;
            end
            count_d = count_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
        end
    end

    // Control state registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            ic_req_q   <= 1'b0;
            ic_addr_q  <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            head_q     <= {PW{1'b0}};
            tail_q     <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
        end else begin
            state_q    <= state_d;
            ic_req_q   <= ic_req_d;
            ic_addr_q  <= ic_addr_d;
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Queue storage; entries are only observed while counted as occupied.
    always_ff @(posedge HCLK) begin
        if (push_s && !bus.redirect_valid) begin
            q_data_q[tail_q] <= bus.ic_data;
            q_pc_q[tail_q]   <= ic_addr_q;
        end
    end

    assign bus.ic_req      = ic_req_q;
    assign bus.ic_addr     = ic_addr_q;
    assign bus.q_count     = count_q;
    assign bus.instr_valid = (count_q != {CW{1'b0}});
    assign bus.instr_data  = bus.instr_valid ? q_data_q[head_q] : 32'h0000_0000;
    assign bus.instr_pc    = bus.instr_valid ? q_pc_q[head_q]   : 32'h0000_0000;
endmodule
